// File: rtl/ram1_uart_bus_arbiter.sv
// Shared RAM1/UART bus sequencer: round-robin arbitration between a 16-bit SRAM
// requester and an 8-bit UART requester, with cycle-accurate strobe generation.
module ram1_uart_bus_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_req,
  input  logic        ram_we,
  input  logic [17:0] ram_addr,
  input  logic [15:0] ram_wdata,
  output logic [15:0] ram_rdata,
  output logic        ram_done,
  input  logic        uart_rd_req,
  input  logic        uart_wr_req,
  input  logic [7:0]  uart_wdata,
  output logic [7:0]  uart_rdata,
  output logic        uart_done,
  output logic        uart_err,
  output logic        busy,
  output logic [17:0] ram1_addr,
  inout  wire  [15:0] ram1_data,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic        ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  typedef enum logic [3:0] {
    IDLE, RR1, RR2, RW1, RW2, RW3, UR1, UR2, UW1, UW2, UW3, UWB, UWS
  } state_e;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          last_uart_q, last_uart_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   ram_rdata_q, ram_rdata_d;
  logic [7:0]    uart_rdata_q, uart_rdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          bus_drive;
  logic          ram_elig, uart_rd_elig, uart_elig, tmo_hit;

  assign ram_elig     = ram_req;
  assign uart_rd_elig = uart_rd_req & data_ready;
  assign uart_elig    = uart_rd_elig | uart_wr_req;
  assign tmo_hit      = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_uart_q  <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      ram_rdata_q  <= '0;
      uart_rdata_q <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_uart_q  <= last_uart_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ram_rdata_q  <= ram_rdata_d;
      uart_rdata_q <= uart_rdata_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_uart_d  = last_uart_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ram_rdata_d  = ram_rdata_q;
    uart_rdata_d = uart_rdata_q;
    tmo_d        = tmo_q;
    ram1EN       = 1'b1;
    ram1OE       = 1'b1;
    ram1WE       = 1'b1;
    rdn          = 1'b1;
    wrn          = 1'b1;
    bus_drive    = 1'b0;
    ram_done     = 1'b0;
    uart_done    = 1'b0;
    uart_err     = 1'b0;

    case (state_q)
      IDLE: begin
        // RAM wins when it is alone, or when both contend and UART had the last turn
        if (ram_elig && (!uart_elig || last_uart_q)) begin
          last_uart_d = 1'b0;
          addr_d      = ram_addr;
          wdata_d     = ram_wdata;
          state_d     = ram_we ? RW1 : RR1;
        end else if (uart_elig) begin
          last_uart_d = 1'b1;
          if (uart_rd_elig) begin
            state_d = UR1;
          end else begin
            wdata_d = {8'h00, uart_wdata};
            state_d = UW1;
          end
        end
      end
      RR1: begin
        ram1EN  = 1'b0;
        ram1OE  = 1'b0;
        state_d = RR2;
      end
      RR2: begin
        ram1EN      = 1'b0;
        ram1OE      = 1'b0;
        ram_done    = 1'b1;
        ram_rdata_d = ram1_data;
        state_d     = IDLE;
      end
      RW1: begin
        ram1EN    = 1'b0;
        bus_drive = 1'b1;
        state_d   = RW2;
      end
      RW2: begin
        ram1EN    = 1'b0;
        ram1WE    = 1'b0;
        bus_drive = 1'b1;
        state_d   = RW3;
      end
      RW3: begin
        ram1EN    = 1'b0;
        bus_drive = 1'b1;
        ram_done  = 1'b1;
        state_d   = IDLE;
      end
      UR1: begin
        rdn     = 1'b0;
        state_d = UR2;
      end
      UR2: begin
        rdn          = 1'b0;
        uart_done    = 1'b1;
        uart_rdata_d = ram1_data[7:0];
        state_d      = IDLE;
      end
      UW1: begin
        bus_drive = 1'b1;
        state_d   = UW2;
      end
      UW2: begin
        bus_drive = 1'b1;
        wrn       = 1'b0;
        state_d   = UW3;
      end
      UW3: begin
        bus_drive = 1'b1;
        tmo_d     = '0;
        state_d   = UWB;
      end
      UWB: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          uart_done = 1'b1;
          uart_err  = 1'b1;
          state_d   = IDLE;
        end else if (tbre) begin
          state_d = UWS;
        end
      end
      UWS: begin
        tmo_d = tmo_q + TW'(1);
        // A completion seen on the final wait cycle still counts as success
        if (tsre) begin
          uart_done = 1'b1;
          state_d   = IDLE;
        end else if (tmo_hit) begin
          uart_done = 1'b1;
          uart_err  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded during the done cycle so the requester can take it on that edge
  assign ram_rdata  = (state_q == RR2) ? ram1_data : ram_rdata_q;
  assign uart_rdata = (state_q == UR2) ? ram1_data[7:0] : uart_rdata_q;
  assign ram1_addr  = addr_q;
  assign busy       = (state_q != IDLE);
  assign ram1_data  = bus_drive ? wdata_q : {16{1'bz}};

endmodule

// File: tb/tb_ram1_uart_bus_arbiter.sv
// Directed bench for ram1_uart_bus_arbiter: per-cycle vector table plus
// hand-written sequences for timeout, round-robin, blocking and async reset.
module tb_ram1_uart_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_req = 1'b0, ram_we = 1'b0;
  logic [17:0] ram_addr = 18'h00010;
  logic [15:0] ram_wdata = 16'hBEEF;
  logic [15:0] ram_rdata;
  logic        ram_done;
  logic        uart_rd_req = 1'b0, uart_wr_req = 1'b0;
  logic [7:0]  uart_wdata = 8'hA5;
  logic [7:0]  uart_rdata;
  logic        uart_done, uart_err, busy;
  logic [17:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        ram1OE, ram1WE, ram1EN, rdn, wrn;
  logic        data_ready = 1'b0, tbre = 1'b0, tsre = 1'b0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_bus = 16'h0000;

  int errors = 0;
  int checks = 0;

  assign ram1_data = tb_drv ? tb_bus : {16{1'bz}};

  always #5 clk = ~clk;

  ram1_uart_bus_arbiter #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done),
    .uart_rd_req(uart_rd_req), .uart_wr_req(uart_wr_req), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_done(uart_done), .uart_err(uart_err), .busy(busy),
    .ram1_addr(ram1_addr), .ram1_data(ram1_data),
    .ram1OE(ram1OE), .ram1WE(ram1WE), .ram1EN(ram1EN), .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  // {busy, EN, OE, WE, rdn, wrn, ram_done, uart_done, uart_err}
  localparam logic [8:0] S_IDLE = 9'b0_1_1_1_1_1_0_0_0;
  localparam logic [8:0] S_RW1  = 9'b1_0_1_1_1_1_0_0_0;
  localparam logic [8:0] S_RW2  = 9'b1_0_1_0_1_1_0_0_0;
  localparam logic [8:0] S_RW3  = 9'b1_0_1_1_1_1_1_0_0;
  localparam logic [8:0] S_RR1  = 9'b1_0_0_1_1_1_0_0_0;
  localparam logic [8:0] S_RR2  = 9'b1_0_0_1_1_1_1_0_0;
  localparam logic [8:0] S_UR1  = 9'b1_1_1_1_0_1_0_0_0;
  localparam logic [8:0] S_UR2  = 9'b1_1_1_1_0_1_0_1_0;
  localparam logic [8:0] S_UWX  = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] S_UW2  = 9'b1_1_1_1_1_0_0_0_0;
  localparam logic [8:0] S_UWD  = 9'b1_1_1_1_1_1_0_1_0;

  typedef struct {
    logic        req, we, urd, uwr, drdy, tb_re, ts_re, drv;
    logic [15:0] bus;
    logic [8:0]  exp;
    logic        chk_bus;
    logic [15:0] exp_bus;
    logic [15:0] exp_rrd;
    logic [7:0]  exp_urd;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic [7:0] in_bits, input logic [15:0] bus,
                              input logic [8:0] exp, input logic chk_bus,
                              input logic [15:0] exp_bus, input logic [15:0] rrd,
                              input logic [7:0] urd);
    vec_t v;
    {v.req, v.we, v.urd, v.uwr, v.drdy, v.tb_re, v.ts_re, v.drv} = in_bits;
    v.bus = bus; v.exp = exp; v.chk_bus = chk_bus; v.exp_bus = exp_bus;
    v.exp_rrd = rrd; v.exp_urd = urd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {busy, ram1EN, ram1OE, ram1WE, rdn, wrn, ram_done, uart_done, uart_err};
  endfunction

  task automatic wait_ram_done(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_done) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int found;
    int cnt_r, cnt_u, rdn_low;
    int order[$];

    // in bits: {req, we, urd, uwr, drdy, tbre, tsre, drv}
    vecs[0]  = mk(8'b1100_0000, 16'h0000, S_IDLE, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[1]  = mk(8'b1100_0000, 16'h0000, S_RW1,  1, 16'hBEEF, 16'h0000, 8'h00);
    vecs[2]  = mk(8'b1100_0000, 16'h0000, S_RW2,  1, 16'hBEEF, 16'h0000, 8'h00);
    vecs[3]  = mk(8'b1100_0000, 16'h0000, S_RW3,  1, 16'hBEEF, 16'h0000, 8'h00);
    vecs[4]  = mk(8'b1000_0001, 16'hBEEF, S_IDLE, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[5]  = mk(8'b1000_0001, 16'hBEEF, S_RR1,  0, 16'h0000, 16'h0000, 8'h00);
    vecs[6]  = mk(8'b1000_0001, 16'hBEEF, S_RR2,  0, 16'h0000, 16'hBEEF, 8'h00);
    vecs[7]  = mk(8'b0010_1001, 16'hFF5A, S_IDLE, 0, 16'h0000, 16'hBEEF, 8'h00);
    vecs[8]  = mk(8'b0010_1001, 16'hFF5A, S_UR1,  0, 16'h0000, 16'hBEEF, 8'h00);
    vecs[9]  = mk(8'b0010_1001, 16'hFF5A, S_UR2,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[10] = mk(8'b0000_0000, 16'h0000, S_IDLE, 0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[11] = mk(8'b0000_0000, 16'h0000, S_IDLE, 0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[12] = mk(8'b0001_0000, 16'h0000, S_IDLE, 0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[13] = mk(8'b0001_0000, 16'h0000, S_UWX,  1, 16'h00A5, 16'hBEEF, 8'h5A);
    vecs[14] = mk(8'b0001_0000, 16'h0000, S_UW2,  1, 16'h00A5, 16'hBEEF, 8'h5A);
    vecs[15] = mk(8'b0001_0000, 16'h0000, S_UWX,  1, 16'h00A5, 16'hBEEF, 8'h5A);
    vecs[16] = mk(8'b0001_0000, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[17] = mk(8'b0001_0000, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[18] = mk(8'b0001_0000, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[19] = mk(8'b0001_0000, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[20] = mk(8'b0001_0100, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[21] = mk(8'b0001_0100, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[22] = mk(8'b0001_0100, 16'h0000, S_UWX,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[23] = mk(8'b0001_0110, 16'h0000, S_UWD,  0, 16'h0000, 16'hBEEF, 8'h5A);
    vecs[24] = mk(8'b0000_0110, 16'h0000, S_IDLE, 0, 16'h0000, 16'hBEEF, 8'h5A);

    // Reset state
    #12;
    chk("reset strobes", 32'(strobes()), 32'(S_IDLE));
    chk("reset ram1_addr", 32'(ram1_addr), 32'h0);
    chk("reset ram_rdata", 32'(ram_rdata), 32'h0);
    chk("reset uart_rdata", 32'(uart_rdata), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      ram_req = vecs[i].req;   ram_we = vecs[i].we;
      uart_rd_req = vecs[i].urd; uart_wr_req = vecs[i].uwr;
      data_ready = vecs[i].drdy; tbre = vecs[i].tb_re; tsre = vecs[i].ts_re;
      tb_drv = vecs[i].drv; tb_bus = vecs[i].bus;
      @(negedge clk);
      chk($sformatf("v%0d strobes", i), 32'(strobes()), 32'(vecs[i].exp));
      chk($sformatf("v%0d ram_rdata", i), 32'(ram_rdata), 32'(vecs[i].exp_rrd));
      chk($sformatf("v%0d uart_rdata", i), 32'(uart_rdata), 32'(vecs[i].exp_urd));
      if (vecs[i].chk_bus)
        chk($sformatf("v%0d bus", i), 32'(ram1_data), 32'(vecs[i].exp_bus));
    end
    chk("addr held in idle", 32'(ram1_addr), 32'h00010);

    // Transmit timeout: tbre never rises
    @(posedge clk); #1;
    uart_wr_req = 1'b1; tbre = 1'b0; tsre = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!wrn) begin found = 1; break; end
    end
    chk("tmo wrn low seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("tmo UW3 bus", 32'(ram1_data), 32'h00A5);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (uart_done) begin n = k; break; end
    end
    chk("tmo done latency", 32'(n), 32'd16);
    chk("tmo err with done", 32'(uart_err), 32'd1);
    @(posedge clk); #1;
    uart_wr_req = 1'b0;
    ram_req = 1'b1; ram_we = 1'b0; ram_addr = 18'h00022;
    tb_drv = 1'b1; tb_bus = 16'h1234;
    wait_ram_done(n);
    chk("post-tmo read latency", 32'(n), 32'd3);
    chk("post-tmo rdata", 32'(ram_rdata), 32'h1234);
    chk("post-tmo addr", 32'(ram1_addr), 32'h00022);
    @(posedge clk); #1;
    ram_req = 1'b0; tb_drv = 1'b0;

    // Round-robin from reset with both sides requesting continuously
    @(posedge clk); #1;
    rst = 1'b0;
    ram_req = 1'b1; ram_we = 1'b1; ram_addr = 18'h00030; ram_wdata = 16'h0F0F;
    uart_wr_req = 1'b1; tbre = 1'b1; tsre = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 200 && order.size() < 4; k++) begin
      @(negedge clk);
      if (ram_done) order.push_back(0);
      if (uart_done) order.push_back(1);
    end
    chk("rr grant count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr grant %0d", k), (k < order.size()) ? 32'(order[k]) : 32'hFFFF, 32'(k % 2));

    // Read request without data_ready must not block RAM
    @(posedge clk); #1;
    rst = 1'b0; ram_req = 1'b0; uart_wr_req = 1'b0;
    #1;
    tb_drv = 1'b1; tb_bus = 16'h7777;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    ram_req = 1'b1; ram_we = 1'b0; uart_rd_req = 1'b1; data_ready = 1'b0;
    cnt_r = 0; cnt_u = 0; rdn_low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ram_done) cnt_r++;
      if (uart_done) cnt_u++;
      if (!rdn) rdn_low++;
    end
    chk("blocked ram grants", 32'(cnt_r), 32'd10);
    chk("blocked uart grants", 32'(cnt_u), 32'd0);
    chk("blocked rdn low", 32'(rdn_low), 32'd0);

    // Async reset during RW2
    @(posedge clk); #1;
    ram_req = 1'b0; uart_rd_req = 1'b0; tb_drv = 1'b0;
    @(posedge clk); #1;
    ram_req = 1'b1; ram_we = 1'b1; ram_addr = 18'h00040; ram_wdata = 16'hCAFE;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ram1WE) begin found = 1; break; end
    end
    chk("rst RW2 reached", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst WE", 32'(ram1WE), 32'd1);
    chk("rst EN", 32'(ram1EN), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst addr", 32'(ram1_addr), 32'h0);
    cnt_r = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ram_done) cnt_r++;
    end
    chk("rst no done", 32'(cnt_r), 32'd0);
    rst = 1'b1;
    wait_ram_done(n);
    chk("rst fresh write latency", 32'(n), 32'd3);
    chk("rst fresh addr", 32'(ram1_addr), 32'h00040);
    @(posedge clk); #1;
    ram_we = 1'b0; tb_drv = 1'b1; tb_bus = 16'hCAFE;
    wait_ram_done(n);
    chk("rst readback latency", 32'(n), 32'd3);
    chk("rst readback data", 32'(ram_rdata), 32'hCAFE);
    @(posedge clk); #1;
    ram_req = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    chk("final idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
